mem_access_module: RTL and testbench
====================================

Name: mem_access_module

Overview:
MIPS MEM pipeline stage, the consumer of the EX/MEM register.
- Takes ALU result, store data, destination register and wb/mem control from EX/MEM.
- Performs byte, half and word loads and stores over a request/ack data-memory port, and stalls the pipeline while memory is busy.
- Owns the MEM/WB register, including the forwarding value returned to the hazard unit as the MEM/WB source.

Parameters:
NB_BITS, 32, datapath width
NB_CTL, 8, width of wb/mem control buses
TIMEOUT, 15, max wait cycles for i_dmem_ack before abort (4-bit counter)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_alu_out  in  NB_BITS  EX/MEM ALU result; used as the memory address
i_data_reg  in  NB_BITS  EX/MEM store data (rt)
i_reg_dst  in  5  EX/MEM destination register
i_wb_ctl  in  NB_CTL  [0]=reg_write, [1]=mem_to_reg
i_mem_ctl  in  NB_CTL  [0]=read, [1]=write, [3:2]=size (00 B, 01 H, 10 W), [4]=unsigned load
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1=store
o_dmem_addr  out  NB_BITS  word-aligned address {addr[31:2],2'b00}
o_dmem_be  out  4  byte enables
o_dmem_wdata  out  NB_BITS  store data replicated into lanes
i_dmem_ack  in  1  request accepted/completed; read data valid this cycle
i_dmem_rdata  in  NB_BITS  read word
o_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
o_misalign  out  1  one-cycle pulse, misaligned access dropped
o_bus_err  out  1  one-cycle pulse, timeout abort
o_wb_ctl  out  NB_CTL  MEM/WB control
o_mem_data  out  NB_BITS  MEM/WB extended load data
o_alu_out  out  NB_BITS  MEM/WB ALU result
o_reg_dst  out  5  MEM/WB destination
o_fwd_data  out  NB_BITS  o_mem_data if o_wb_ctl[1] else o_alu_out

Behaviour:
Reset:
- Reset is asynchronous on i_rst_n low.
- MEM/WB outputs, o_misalign, o_bus_err and the wait counter all go to 0; FSM goes to IDLE.

Memory operations:
- An access is a memop when read|write is set. If read and write are both set, it is a write.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
- A misaligned memop issues no request, pulses o_misalign, and loads MEM/WB with wb_ctl=0 (bubble). It is never stalled.

Byte lanes:
- B: be=1<<addr[1:0], wdata={4{d[7:0]}}.
- H: be=addr[1]?1100:0011, wdata={2{d[15:0]}}.
- W: be=1111, wdata=d.
- Load extract uses the same lane selection; sign-extend unless [4] is set.
- Size 11 is treated as W.

FSM IDLE/WAIT:
- IDLE, aligned memop: o_dmem_req=1 combinationally.
  - If i_dmem_ack is high the same cycle, the access completes with zero wait and MEM/WB loads.
  - Otherwise o_stall=1, go to WAIT, counter=1.
- WAIT: o_dmem_req held with address, be, we and wdata stable (inputs are frozen by the stall).
  - On ack: o_stall=0, MEM/WB loads, go to IDLE.
  - If counter==TIMEOUT without ack: drop req, pulse o_bus_err, MEM/WB bubble, o_stall=0, go to IDLE.
  - Otherwise increment the counter.
- o_stall = aligned memop && !i_dmem_ack, in both states. The timeout cycle is the exception: o_stall=0.

MEM/WB register:
- Loads every cycle in which o_stall=0.
- During stall cycles it loads a bubble (wb_ctl=0) so the previous instruction is not re-written.
- Non-memop instructions pass through in 1 cycle, with o_mem_data=0.
- Stores: o_mem_data=0 and wb_ctl passes through as given.

Corner cases:
- i_dmem_ack while no request is outstanding is ignored.
- Reset in WAIT aborts the access immediately; no pulse is produced.

Decomposition:
- Shared include holds bit-index and size constants: MEM_RD, MEM_WR, MEM_SZ_B/H/W, MEM_UNS, WB_REGW, WB_MEM2REG. The existing control encoder uses these same constants.
- One sub-module, mem_lane_align: combinational be/wdata generation and load extract/extend.

Test Plan:
- ALU pass-through, alu=0x00000010, reg_dst=5, wb=01, mem_ctl=0 -> next cycle o_alu_out=0x10, o_reg_dst=5, o_fwd_data=0x10, no req.
- Word store to 0x104, data 0xDEADBEEF, ack after 2 cycles -> req held 3 cycles, be=1111, addr=0x104, o_stall high 2 cycles, then MEM/WB loads.
- Signed byte load addr 0x203, rdata 0x80FF7F01, zero-wait ack -> o_mem_data=0xFFFFFF80, o_fwd_data same; the unsigned variant gives 0x00000080.
- Half store to 0x302, data 0x1234ABCD -> be=1100, wdata=0xABCDABCD.
- Word load to 0x101 -> no req, o_misalign pulses once, o_wb_ctl=0, o_stall never high.
- Load with no ack -> o_bus_err pulse after TIMEOUT=15 cycles, bubble, stall released. Also: assert i_rst_n low mid-WAIT -> req and outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_access_module_pkg.sv
// rtl/mem_access_module_pkg.sv - control-bit indices, size codes and FSM state shared by the MEM stage
package mem_access_module_pkg;

    // i_mem_ctl bit positions
    localparam int MEM_RD    = 0;
    localparam int MEM_WR    = 1;
    localparam int MEM_SZ_LO = 2;
    localparam int MEM_SZ_HI = 3;
    localparam int MEM_UNS   = 4;

    // Access size codes carried in i_mem_ctl[MEM_SZ_HI:MEM_SZ_LO]; 2'b11 behaves as a word
    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    // i_wb_ctl bit positions
    localparam int WB_REGW    = 0;
    localparam int WB_MEM2REG = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Natural alignment: halves on even addresses, words (and size 11) on multiples of four
    function automatic logic mem_is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_SZ_B: mem_is_aligned = 1'b1;
            MEM_SZ_H: mem_is_aligned = ~addr_lo[0];
            default:  mem_is_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication and load extract/extend
//
// Ports:
//   addr_lo    in   low two address bits selecting the lane
//   size       in   access size code (B/H/W, 11 treated as W)
//   uns        in   1 = zero-extend loads, 0 = sign-extend
//   store_data in   register value to store
//   rdata      in   word returned by data memory
//   be         out  byte enables for the store
//   wdata      out  store data replicated into every lane
//   load_data  out  selected lane, extended to NB_BITS
module mem_lane_align
    import mem_access_module_pkg::*;
#(
    parameter int NB_BITS = 32
) (
    input  logic [1:0]         addr_lo,
    input  logic [1:0]         size,
    input  logic               uns,
    input  logic [NB_BITS-1:0] store_data,
    input  logic [NB_BITS-1:0] rdata,
    output logic [3:0]         be,
    output logic [NB_BITS-1:0] wdata,
    output logic [NB_BITS-1:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = rdata[{addr_lo, 3'b000} +: 8];
        ld_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            MEM_SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {(NB_BITS/8){store_data[7:0]}};
                load_data = {{(NB_BITS-8){ld_byte[7] & ~uns}}, ld_byte};
            end
            MEM_SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {(NB_BITS/16){store_data[15:0]}};
                load_data = {{(NB_BITS-16){ld_half[15] & ~uns}}, ld_half};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_module.sv
// rtl/mem_access_module.sv - MIPS MEM stage: data-memory access FSM and MEM/WB register
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_alu_out .. i_mem_ctl    EX/MEM register contents (address, store data, dest, controls)
//   o_dmem_*                  request/ack data-memory port (req, we, word address, be, wdata)
//   i_dmem_ack, i_dmem_rdata  memory acknowledge and read word
//   o_stall                   freezes the upstream pipeline while an access is outstanding
//   o_misalign, o_bus_err     one-cycle pulses: misaligned access dropped / timeout abort
//   o_wb_ctl .. o_reg_dst     MEM/WB register
//   o_fwd_data                MEM/WB forwarding value for the hazard unit
module mem_access_module
    import mem_access_module_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int NB_CTL  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_BITS-1:0] i_alu_out,
    input  logic [NB_BITS-1:0] i_data_reg,
    input  logic [4:0]         i_reg_dst,
    input  logic [NB_CTL-1:0]  i_wb_ctl,
    input  logic [NB_CTL-1:0]  i_mem_ctl,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [NB_BITS-1:0] o_dmem_addr,
    output logic [3:0]         o_dmem_be,
    output logic [NB_BITS-1:0] o_dmem_wdata,
    input  logic               i_dmem_ack,
    input  logic [NB_BITS-1:0] i_dmem_rdata,
    output logic               o_stall,
    output logic               o_misalign,
    output logic               o_bus_err,
    output logic [NB_CTL-1:0]  o_wb_ctl,
    output logic [NB_BITS-1:0] o_mem_data,
    output logic [NB_BITS-1:0] o_alu_out,
    output logic [4:0]         o_reg_dst,
    output logic [NB_BITS-1:0] o_fwd_data
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    mem_state_t         state;
    logic [3:0]         wait_cnt;

    logic               rd;
    logic               wr;
    logic [1:0]         size;
    logic               uns;
    logic               memop;
    logic               is_load;
    logic               aligned;
    logic               req_valid;
    logic               misalign_now;
    logic               active;
    logic               timeout_now;
    logic [NB_BITS-1:0] load_data;
    logic               unused_ctl;

    assign rd           = i_mem_ctl[MEM_RD];
    assign wr           = i_mem_ctl[MEM_WR];
    assign size         = i_mem_ctl[MEM_SZ_HI:MEM_SZ_LO];
    assign uns          = i_mem_ctl[MEM_UNS];
    assign memop        = rd | wr;
    // read+write together resolves to a store
    assign is_load      = rd & ~wr;
    assign aligned      = mem_is_aligned(size, i_alu_out[1:0]);
    assign req_valid    = memop & aligned;
    assign misalign_now = memop & ~aligned;
    assign unused_ctl   = ^i_mem_ctl[NB_CTL-1:MEM_UNS+1];

    // In WAIT the EX/MEM inputs are frozen, so the request stays asserted from state alone
    assign active      = (state == ST_WAIT) | req_valid;
    assign timeout_now = (state == ST_WAIT) & ~i_dmem_ack & (wait_cnt == TIMEOUT_CNT);

    // Gated by reset so an aborted access drops its request without waiting for a clock
    assign o_dmem_req   = i_rst_n & active;
    assign o_stall      = i_rst_n & active & ~i_dmem_ack & ~timeout_now;
    assign o_dmem_we    = wr;
    assign o_dmem_addr  = {i_alu_out[NB_BITS-1:2], 2'b00};

    mem_lane_align #(
        .NB_BITS (NB_BITS)
    ) u_lane (
        .addr_lo    (i_alu_out[1:0]),
        .size       (size),
        .uns        (uns),
        .store_data (i_data_reg),
        .rdata      (i_dmem_rdata),
        .be         (o_dmem_be),
        .wdata      (o_dmem_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
            o_wb_ctl   <= '0;
            o_mem_data <= '0;
            o_alu_out  <= '0;
            o_reg_dst  <= '0;
        end else begin
            o_misalign <= misalign_now;
            o_bus_err  <= timeout_now;

            case (state)
                ST_IDLE: begin
                    if (req_valid && !i_dmem_ack) begin
                        state    <= ST_WAIT;
                        wait_cnt <= 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (i_dmem_ack || timeout_now) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase

            // Stall, misaligned drop and timeout all hand WB a bubble so nothing retires twice
            if (o_stall || misalign_now || timeout_now) begin
                o_wb_ctl   <= '0;
                o_mem_data <= '0;
                o_alu_out  <= '0;
                o_reg_dst  <= '0;
            end else begin
                o_wb_ctl   <= i_wb_ctl;
                o_alu_out  <= i_alu_out;
                o_reg_dst  <= i_reg_dst;
                o_mem_data <= (memop && is_load) ? load_data : '0;
            end
        end
    end

    assign o_fwd_data = o_wb_ctl[WB_MEM2REG] ? o_mem_data : o_alu_out;

endmodule

// File: tb/tb_mem_access_module.sv
// tb/tb_mem_access_module.sv - self-checking bench for mem_access_module
module tb_mem_access_module;

    localparam int NB_BITS = 32;
    localparam int NB_CTL  = 8;
    localparam int TIMEOUT = 15;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [31:0]       i_alu_out;
    logic [31:0]       i_data_reg;
    logic [4:0]        i_reg_dst;
    logic [7:0]        i_wb_ctl;
    logic [7:0]        i_mem_ctl;
    logic              o_dmem_req;
    logic              o_dmem_we;
    logic [31:0]       o_dmem_addr;
    logic [3:0]        o_dmem_be;
    logic [31:0]       o_dmem_wdata;
    logic              i_dmem_ack;
    logic [31:0]       i_dmem_rdata;
    logic              o_stall;
    logic              o_misalign;
    logic              o_bus_err;
    logic [7:0]        o_wb_ctl;
    logic [31:0]       o_mem_data;
    logic [31:0]       o_alu_out;
    logic [4:0]        o_reg_dst;
    logic [31:0]       o_fwd_data;

    always #5 i_clk = ~i_clk;

    mem_access_module #(
        .NB_BITS (NB_BITS),
        .NB_CTL  (NB_CTL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_alu_out    (i_alu_out),
        .i_data_reg   (i_data_reg),
        .i_reg_dst    (i_reg_dst),
        .i_wb_ctl     (i_wb_ctl),
        .i_mem_ctl    (i_mem_ctl),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_stall      (o_stall),
        .o_misalign   (o_misalign),
        .o_bus_err    (o_bus_err),
        .o_wb_ctl     (o_wb_ctl),
        .o_mem_data   (o_mem_data),
        .o_alu_out    (o_alu_out),
        .o_reg_dst    (o_reg_dst),
        .o_fwd_data   (o_fwd_data)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic check_en  = 1'b0;

    // Expected per-cycle memory-port values and the expected MEM/WB register contents
    logic        exp_req, exp_stall, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [7:0]  exp_wb;
    logic [31:0] exp_mem, exp_alu;
    logic [4:0]  exp_dst;
    logic        exp_mis, exp_berr;

    int          n_req, n_stall;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_aligned(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return (a % 2) == 0;
        return a == 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return (a >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdw, input logic [1:0] a,
                                           input logic [1:0] sz, input logic u);
        longint v;
        int     nbytes;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = longint'(rdw) >> (8 * a);
        v = v % (64'sd1 << (8 * nbytes));
        if (!u && nbytes < 4 && v >= (64'sd1 << (8 * nbytes - 1)))
            v = v - (64'sd1 << (8 * nbytes));
        return v[31:0];
    endfunction

    task automatic exp_bubble();
        exp_wb  = '0;
        exp_mem = '0;
        exp_alu = '0;
        exp_dst = '0;
    endtask

    always @(negedge i_clk) begin
        if (check_en) begin
            chk("req", 32'(o_dmem_req), 32'(exp_req));
            chk("stall", 32'(o_stall), 32'(exp_stall));
            if (exp_req) begin
                chk("we", 32'(o_dmem_we), 32'(exp_we));
                chk("addr", o_dmem_addr, exp_addr);
                chk("be", 32'(o_dmem_be), 32'(exp_be));
                chk("wdata", o_dmem_wdata, exp_wdata);
            end
            chk("wb_ctl", 32'(o_wb_ctl), 32'(exp_wb));
            chk("mem_data", o_mem_data, exp_mem);
            chk("alu_out", o_alu_out, exp_alu);
            chk("reg_dst", 32'(o_reg_dst), 32'(exp_dst));
            chk("fwd_data", o_fwd_data, exp_wb[1] ? exp_mem : exp_alu);
            chk("misalign", 32'(o_misalign), 32'(exp_mis));
            chk("bus_err", 32'(o_bus_err), 32'(exp_berr));
        end
        if (o_dmem_req) begin
            n_req++;
            seen_addr  = o_dmem_addr;
            seen_be    = o_dmem_be;
            seen_wdata = o_dmem_wdata;
        end
        if (o_stall) n_stall++;
    end

    // One EX/MEM instruction; ack_at = cycle index of the ack (-1: never). Returns 1 ns after
    // the edge on which the instruction retired into MEM/WB.
    task automatic op(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] dst,
                      input logic [7:0] wb, input logic [7:0] mem, input int ack_at,
                      input logic [31:0] rdw);
        logic       memop, ok, is_load, ack_now, tmo, done;
        logic [1:0] sz, a;
        sz      = mem[3:2];
        a       = alu[1:0];
        memop   = mem[0] | mem[1];
        is_load = mem[0] & ~mem[1];
        ok      = m_aligned(sz, a);
        i_alu_out    = alu;
        i_data_reg   = data;
        i_reg_dst    = dst;
        i_wb_ctl     = wb;
        i_mem_ctl    = mem;
        i_dmem_rdata = rdw;
        n_req   = 0;
        n_stall = 0;
        done    = 1'b0;
        for (int k = 0; k <= TIMEOUT && !done; k++) begin
            ack_now    = (k == ack_at);
            i_dmem_ack = ack_now;
            tmo        = memop && ok && !ack_now && (k == TIMEOUT);
            exp_req    = memop && ok;
            exp_stall  = memop && ok && !ack_now && !tmo;
            exp_we     = mem[1];
            exp_addr   = alu & ~32'h3;
            exp_be     = m_be(sz, a);
            exp_wdata  = m_wdata(sz, data);
            @(negedge i_clk);
            @(posedge i_clk);
            #1;
            exp_mis  = 1'b0;
            exp_berr = 1'b0;
            if (exp_stall) begin
                exp_bubble();
            end else begin
                done = 1'b1;
                if (memop && !ok) begin
                    exp_bubble();
                    exp_mis = 1'b1;
                end else if (tmo) begin
                    exp_bubble();
                    exp_berr = 1'b1;
                end else begin
                    exp_wb  = wb;
                    exp_alu = alu;
                    exp_dst = dst;
                    exp_mem = (memop && is_load) ? m_load(rdw, a, sz, mem[4]) : 32'h0;
                end
            end
        end
        i_dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n      = 1'b0;
        i_alu_out    = '0;
        i_data_reg   = '0;
        i_reg_dst    = '0;
        i_wb_ctl     = '0;
        i_mem_ctl    = '0;
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = '0;
        exp_req = 0; exp_stall = 0; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
        exp_mis = 0; exp_berr = 0;
        exp_bubble();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        chk("rst_wb_ctl", 32'(o_wb_ctl), 32'h0);
        chk("rst_fwd", o_fwd_data, 32'h0);
        chk("rst_bus_err", 32'(o_bus_err), 32'h0);
        check_en = 1'b1;

        // ALU pass-through
        op(32'h10, 32'h0, 5'd5, 8'h01, 8'h00, -1, 32'h0);
        chk("pt_alu", o_alu_out, 32'h10);
        chk("pt_dst", 32'(o_reg_dst), 32'd5);
        chk("pt_fwd", o_fwd_data, 32'h10);
        chk("pt_nreq", 32'(n_req), 32'd0);

        // Word store, ack after two wait cycles
        op(32'h104, 32'hDEADBEEF, 5'd0, 8'h00, 8'h0A, 2, 32'h0);
        chk("sw_nreq", 32'(n_req), 32'd3);
        chk("sw_nstall", 32'(n_stall), 32'd2);
        chk("sw_addr", seen_addr, 32'h104);
        chk("sw_be", 32'(seen_be), 32'hF);
        chk("sw_mem", o_mem_data, 32'h0);

        // Byte loads, zero wait, signed then unsigned
        op(32'h203, 32'h0, 5'd7, 8'h03, 8'h01, 0, 32'h80FF7F01);
        chk("lb_mem", o_mem_data, 32'hFFFFFF80);
        chk("lb_fwd", o_fwd_data, 32'hFFFFFF80);
        chk("lb_nstall", 32'(n_stall), 32'd0);
        op(32'h203, 32'h0, 5'd7, 8'h03, 8'h11, 0, 32'h80FF7F01);
        chk("lbu_mem", o_mem_data, 32'h00000080);

        // Half store on the upper half
        op(32'h302, 32'h1234ABCD, 5'd0, 8'h00, 8'h06, 1, 32'h0);
        chk("sh_be", 32'(seen_be), 32'hC);
        chk("sh_wdata", seen_wdata, 32'hABCDABCD);

        // Misaligned word load
        op(32'h101, 32'h0, 5'd9, 8'h03, 8'h09, 0, 32'h11111111);
        chk("mis_pulse", 32'(o_misalign), 32'h1);
        chk("mis_wb", 32'(o_wb_ctl), 32'h0);
        chk("mis_nstall", 32'(n_stall), 32'd0);
        chk("mis_nreq", 32'(n_req), 32'd0);

        // More lane / size patterns
        op(32'h102, 32'h0, 5'd3, 8'h03, 8'h05, 3, 32'h80011234);
        chk("lh_mem", o_mem_data, 32'hFFFF8001);
        op(32'h200, 32'h0, 5'd4, 8'h03, 8'h09, 1, 32'h12345678);
        op(32'h000, 32'h00C0FFEE, 5'd2, 8'h03, 8'h0B, 0, 32'h0);
        chk("rw_is_store_mem", o_mem_data, 32'h0);
        op(32'h004, 32'h0, 5'd6, 8'h03, 8'h0D, 0, 32'hCAFEF00D);
        chk("sz11_mem", o_mem_data, 32'hCAFEF00D);
        op(32'h301, 32'h00000055, 5'd0, 8'h00, 8'h02, 0, 32'h0);
        chk("sb_be", 32'(seen_be), 32'h2);
        op(32'h302, 32'h0, 5'd1, 8'h03, 8'h15, 0, 32'h9ABC0000);
        chk("lhu_mem", o_mem_data, 32'h00009ABC);

        // Unsolicited ack with no request outstanding
        op(32'h44, 32'h0, 5'd8, 8'h01, 8'h00, 0, 32'hFFFFFFFF);
        chk("stray_ack_alu", o_alu_out, 32'h44);

        // Timeout abort
        op(32'h400, 32'h0, 5'd10, 8'h03, 8'h09, -1, 32'h0);
        chk("tmo_nstall", 32'(n_stall), 32'd15);
        chk("tmo_bus_err", 32'(o_bus_err), 32'h1);
        chk("tmo_wb", 32'(o_wb_ctl), 32'h0);
        op(32'h20, 32'h0, 5'd11, 8'h01, 8'h00, -1, 32'h0);
        chk("after_tmo_alu", o_alu_out, 32'h20);

        // Reset in the middle of WAIT
        check_en   = 1'b0;
        i_alu_out  = 32'h500;
        i_reg_dst  = 5'd12;
        i_wb_ctl   = 8'h03;
        i_mem_ctl  = 8'h09;
        i_dmem_ack = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        chk("wait_req", 32'(o_dmem_req), 32'h1);
        chk("wait_stall", 32'(o_stall), 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(o_dmem_req), 32'h0);
        chk("arst_stall", 32'(o_stall), 32'h0);
        chk("arst_wb", 32'(o_wb_ctl), 32'h0);
        chk("arst_alu", o_alu_out, 32'h0);
        chk("arst_bus_err", 32'(o_bus_err), 32'h0);
        i_mem_ctl = 8'h00;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        exp_bubble();
        exp_mis  = 1'b0;
        exp_berr = 1'b0;
        check_en = 1'b1;
        op(32'h30, 32'h0, 5'd13, 8'h01, 8'h00, -1, 32'h0);
        chk("post_rst_alu", o_alu_out, 32'h30);
        op(32'h34, 32'h0, 5'd14, 8'h01, 8'h00, -1, 32'h0);
        @(negedge i_clk);
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
